// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the line-memory arbiter.
// Holds the FSM encoding, default widths and the port-index constants.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;

    localparam logic PORT_IC = 1'b0;
    localparam logic PORT_DC = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin selector.
// A lone requester wins; on contention the port that did not win last time wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       any,
    output logic       winner
);

    // pick the winner from the request pair and the previous grant
    always_comb begin
        any = |req;
        unique case (req)
            2'b01:   winner = PORT_IC;
            2'b10:   winner = PORT_DC;
            2'b11:   winner = ~last;
            default: winner = last;
        endcase
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: shares one line-wide memory port between icache and dcache.
// One transaction at a time, round-robin grant, latched request, sticky watchdog.
module mem_line_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W    = DEF_ADDR_W,
    parameter int          LINE_W    = DEF_LINE_W,
    parameter int unsigned TO_CYCLES = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [LINE_W-1:0] m0_data_i,
    output logic [LINE_W-1:0] m0_data_o,
    output logic              m0_ack_o,

    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [LINE_W-1:0] m1_data_i,
    output logic [LINE_W-1:0] m1_data_o,
    output logic              m1_ack_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,

    output logic              busy_o,
    output logic              grant_o,
    output logic              err_o
);

    // Counter only needs to reach TO_CYCLES, where it parks.
    localparam int CNT_W = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_SAT = CNT_W'(TO_CYCLES);
    localparam bit WD_ON = (TO_CYCLES != 0);

    state_t              state_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   data_q;
    logic                grant_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                any;
    logic                winner;
    logic                busy;

    rr_pick2 u_pick (
        .req    ({m1_enable_i, m0_enable_i}),
        .last   (grant_q),
        .any    (any),
        .winner (winner)
    );

    assign busy = (state_q == BUSY);

    // FSM with request latch, round-robin pointer and watchdog
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            grant_q <= PORT_DC;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any) begin
                        state_q <= BUSY;
                        grant_q <= winner;
                        wr_q    <= (winner == PORT_DC) ? m1_write_i : m0_write_i;
                        addr_q  <= (winner == PORT_DC) ? m1_addr_i : m0_addr_i;
                        data_q  <= (winner == PORT_DC) ? m1_data_i : m0_data_i;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    if (cnt_q != TO_SAT) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (WD_ON && ((cnt_q + 1'b1) == TO_SAT)) begin
                        err_q <= 1'b1;
                    end
                    // Requester inputs are ignored here; only the memory ends it.
                    if (mem_ack_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_enable_o = busy;
    assign mem_write_o  = wr_q;
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = data_q;

    assign busy_o  = busy;
    assign grant_o = grant_q;
    assign err_o   = err_q;

    // Data is broadcast; only the ack tells a port the data is its own.
    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;

    assign m0_ack_o = busy && mem_ack_i && (grant_q == PORT_IC);
    assign m1_ack_o = busy && mem_ack_i && (grant_q == PORT_DC);

endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter: directed stimulus against a transaction-level model
// of the arbiter, plus hand-computed literal expectations per scenario.
module tb_mem_line_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [LW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
    logic          m0_ack_o, m1_ack_o;
    logic          mem_enable_o, mem_write_o, mem_ack_i;
    logic [AW-1:0] mem_addr_o;
    logic [LW-1:0] mem_data_o, mem_data_i;
    logic          busy_o, grant_o, err_o;

    mem_line_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TO_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .busy_o(busy_o), .grant_o(grant_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- transaction-level model ----------------
    logic          md_busy, md_port, md_wr, md_last, md_err;
    logic [AW-1:0] md_addr;
    logic [LW-1:0] md_data;
    int            md_age;
    logic          md_pick;

    // whoever did not win last time wins a tie; a lone requester always wins
    always_comb begin
        md_pick = 1'b0;
        if (m0_enable_i && m1_enable_i) md_pick = (md_last == 1'b1) ? 1'b0 : 1'b1;
        else if (m1_enable_i) md_pick = 1'b1;
    end

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            md_busy <= 1'b0; md_port <= 1'b1; md_wr <= 1'b0;
            md_last <= 1'b1; md_err <= 1'b0; md_addr <= '0;
            md_data <= '0; md_age <= 0;
        end else if (!md_busy) begin
            if (m0_enable_i || m1_enable_i) begin
                md_busy <= 1'b1;
                md_port <= md_pick;
                md_last <= md_pick;
                md_wr   <= md_pick ? m1_write_i : m0_write_i;
                md_addr <= md_pick ? m1_addr_i : m0_addr_i;
                md_data <= md_pick ? m1_data_i : m0_data_i;
                md_age  <= 0;
            end
        end else begin
            if (md_age < (1 << 20)) md_age <= md_age + 1;
            if (TO != 0 && md_age + 1 >= TO) md_err <= 1'b1;
            if (mem_ack_i) md_busy <= 1'b0;
        end
    end

    // compare DUT against the model every cycle outside reset
    always @(negedge clk) begin
        if (!rst_i) begin
            chk("busy", busy_o, md_busy);
            chk("mem_enable", mem_enable_o, md_busy);
            chk("grant", grant_o, md_last);
            chk("err", err_o, md_err);
            chk("m0_ack", m0_ack_o, md_busy && mem_ack_i && !md_port);
            chk("m1_ack", m1_ack_o, md_busy && mem_ack_i && md_port);
            chk("m0_data", m0_data_o, mem_data_i);
            chk("m1_data", m1_data_o, mem_data_i);
            if (md_busy) begin
                chk("mem_write", mem_write_o, md_wr);
                chk("mem_addr", mem_addr_o, md_addr);
                chk("mem_wdata", mem_data_o, md_data);
            end
        end
    end

    // ---------------- observation logs ----------------
    int            ack0_cnt = 0, ack1_cnt = 0, low_run = 0;
    logic          prev_en = 1'b0;
    logic [AW-1:0] tr_addr[$];
    logic          tr_wr[$], tr_port[$];
    logic [LW-1:0] tr_wdata[$], tr_rdata[$];
    logic          gr_log[$];
    int            gap_log[$];

    always @(negedge clk) begin
        if (rst_i) begin
            prev_en <= 1'b0;
            low_run <= 0;
        end else begin
            if (m0_ack_o) ack0_cnt <= ack0_cnt + 1;
            if (m1_ack_o) ack1_cnt <= ack1_cnt + 1;
            if (mem_enable_o && mem_ack_i) begin
                tr_addr.push_back(mem_addr_o);
                tr_wr.push_back(mem_write_o);
                tr_wdata.push_back(mem_data_o);
                tr_port.push_back(grant_o);
                tr_rdata.push_back(grant_o ? m1_data_o : m0_data_o);
            end
            if (mem_enable_o && !prev_en) begin
                gr_log.push_back(grant_o);
                gap_log.push_back(low_run);
            end
            low_run <= mem_enable_o ? 0 : low_run + 1;
            prev_en <= mem_enable_o;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        m0_enable_i = 0; m0_write_i = 0; m0_addr_i = '0; m0_data_i = '0;
        m1_enable_i = 0; m1_write_i = 0; m1_addr_i = '0; m1_data_i = '0;
        mem_ack_i = 0; mem_data_i = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_i = 1;
        clear_inputs();
        repeat (2) begin @(posedge clk); #2; end
        rst_i = 0;
    endtask

    task automatic mem_respond(input int lat, input logic [LW-1:0] d);
        int n = 0;
        while (!mem_enable_o && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("resp_enable_seen", mem_enable_o, 1'b1);
        if (!mem_enable_o) return;
        repeat (lat - 1) begin @(posedge clk); #2; end
        mem_data_i = d;
        mem_ack_i = 1;
        @(posedge clk); #2;
        mem_ack_i = 0;
        mem_data_i = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    int b0, b1, bt, bg, cnt;
    logic [LW-1:0] dw;

    initial begin
        rst_i = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #2 rst_i = 0;
        @(negedge clk);
        chk("rst_grant", grant_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_mem_en", mem_enable_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, '0);

        // single read on port 0
        @(posedge clk); #2;
        b0 = ack0_cnt; b1 = ack1_cnt; bt = tr_addr.size();
        m0_enable_i = 1; m0_write_i = 0; m0_addr_i = 32'h0000_0400;
        @(posedge clk); #2;
        chk("t1_busy", busy_o, 1'b1);
        chk("t1_addr", mem_addr_o, 32'h400);
        chk("t1_write", mem_write_o, 1'b0);
        mem_respond(10, {32{8'hA5}});
        m0_enable_i = 0;
        repeat (2) begin @(posedge clk); #2; end
        chk("t1_ack0_pulses", ack0_cnt - b0, 1);
        chk("t1_ack1_pulses", ack1_cnt - b1, 0);
        chk("t1_tr_count", tr_addr.size() - bt, 1);
        if (tr_addr.size() > bt) chk("t1_rdata", tr_rdata[bt], {32{8'hA5}});

        // contention: grants alternate 0,1,0,1
        do_reset();
        bg = gr_log.size();
        m0_enable_i = 1; m0_addr_i = 32'h100;
        m1_enable_i = 1; m1_addr_i = 32'h200;
        for (int k = 0; k < 4; k++) mem_respond(3, LW'(k + 1));
        m0_enable_i = 0; m1_enable_i = 0;
        repeat (3) begin @(posedge clk); #2; end
        chk("t2_grants", gr_log.size() - bg, 4);
        if (gr_log.size() >= bg + 4) begin
            chk("t2_g0", gr_log[bg], 1'b0);
            chk("t2_g1", gr_log[bg + 1], 1'b1);
            chk("t2_g2", gr_log[bg + 2], 1'b0);
            chk("t2_g3", gr_log[bg + 3], 1'b1);
            chk("t2_gap1", gap_log[bg + 1], 1);
            chk("t2_gap3", gap_log[bg + 3], 1);
        end

        // port 1 write-back then refill
        do_reset();
        bt = tr_addr.size(); b1 = ack1_cnt; bg = gap_log.size();
        dw = {8{32'hDEAD_BEEF}};
        m1_enable_i = 1; m1_write_i = 1; m1_addr_i = 32'h800; m1_data_i = dw;
        mem_respond(4, '0);
        m1_write_i = 0; m1_addr_i = 32'hC00; m1_data_i = '0;
        mem_respond(4, {8{32'h5A5A_0FF0}});
        m1_enable_i = 0;
        repeat (3) begin @(posedge clk); #2; end
        chk("t3_tr_count", tr_addr.size() - bt, 2);
        chk("t3_ack1_pulses", ack1_cnt - b1, 2);
        if (tr_addr.size() >= bt + 2) begin
            chk("t3_wr0", tr_wr[bt], 1'b1);
            chk("t3_addr0", tr_addr[bt], 32'h800);
            chk("t3_wdata0", tr_wdata[bt], dw);
            chk("t3_wr1", tr_wr[bt + 1], 1'b0);
            chk("t3_addr1", tr_addr[bt + 1], 32'hC00);
            chk("t3_port1", tr_port[bt + 1], 1'b1);
            chk("t3_rdata1", tr_rdata[bt + 1], {8{32'h5A5A_0FF0}});
        end
        if (gap_log.size() >= bg + 2) chk("t3_gap", gap_log[bg + 1], 1);

        // port 1 drops enable mid-transaction
        do_reset();
        bt = tr_addr.size(); b1 = ack1_cnt;
        m1_enable_i = 1; m1_write_i = 0; m1_addr_i = 32'h1000;
        @(posedge clk); #2;
        @(posedge clk); #2;
        m1_enable_i = 0; m1_addr_i = 32'h2000;
        chk("t4_still_busy", mem_enable_o, 1'b1);
        chk("t4_addr_held", mem_addr_o, 32'h1000);
        mem_respond(3, {16{16'hC3C3}});
        repeat (2) begin @(posedge clk); #2; end
        chk("t4_ack1_pulses", ack1_cnt - b1, 1);
        chk("t4_idle", busy_o, 1'b0);
        if (tr_addr.size() > bt) chk("t4_tr_addr", tr_addr[bt], 32'h1000);

        // watchdog: no ack
        do_reset();
        b0 = ack0_cnt;
        m0_enable_i = 1; m0_write_i = 0; m0_addr_i = 32'h40;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy_o) cnt++;
            if (err_o) break;
        end
        chk("t5_err_busy_cycles", cnt, 9);
        repeat (5) @(negedge clk);
        chk("t5_err_sticky", err_o, 1'b1);
        @(posedge clk); #2;
        mem_respond(1, {64{4'h9}});
        m0_enable_i = 0;
        repeat (2) begin @(posedge clk); #2; end
        chk("t5_late_ack", ack0_cnt - b0, 1);
        chk("t5_err_after_ack", err_o, 1'b1);
        chk("t5_idle", busy_o, 1'b0);
        do_reset();
        @(negedge clk);
        chk("t5_err_cleared", err_o, 1'b0);

        // asynchronous reset mid-transaction, then a stray ack
        @(posedge clk); #2;
        b0 = ack0_cnt; b1 = ack1_cnt;
        m1_enable_i = 1; m1_write_i = 1; m1_addr_i = 32'h3000; m1_data_i = {8{32'h1234_5678}};
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("t6_busy_before", busy_o, 1'b1);
        rst_i = 1;
        m1_enable_i = 0;
        #1;
        chk("t6_mem_en", mem_enable_o, 1'b0);
        chk("t6_mem_write", mem_write_o, 1'b0);
        chk("t6_mem_addr", mem_addr_o, '0);
        chk("t6_mem_data", mem_data_o, '0);
        chk("t6_busy", busy_o, 1'b0);
        chk("t6_grant", grant_o, 1'b1);
        @(posedge clk); #2;
        rst_i = 0;
        @(posedge clk); #2;
        mem_ack_i = 1; mem_data_i = {32{8'h77}};
        #1;
        chk("t6_stray_ack0", m0_ack_o, 1'b0);
        chk("t6_stray_ack1", m1_ack_o, 1'b0);
        @(posedge clk); #2;
        mem_ack_i = 0;
        repeat (2) begin @(posedge clk); #2; end
        chk("t6_ack_counts", (ack0_cnt - b0) + (ack1_cnt - b1), 0);
        chk("t6_idle", busy_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_line_arbiter.md
# mem_line_arbiter

Two-port arbiter that shares the single line-wide data memory (256-bit enable/write/ack protocol) between the instruction-cache and data-cache refill/write-back controllers. Each cache controller sees a private memory port. The arbiter grants one transaction at a time with round-robin fairness and latches the request so the memory sees stable inputs. It returns data and a single-cycle ack to the granted port only, and flags a watchdog error on stalled transactions.

## Interface
- `ADDR_W`, 32, byte address width
- `LINE_W`, 256, cache-line data width
- `TO_CYCLES`, 1023, busy cycles before `err_o` sets; 0 disables the watchdog

- `clk_i` in 1: system clock
- `rst_i` in 1: reset, asynchronous, active-high
- `m0_enable_i` in 1: port 0 (icache) request; held high until `m0_ack_o`
- `m0_write_i` in 1: port 0 write (1) / read (0)
- `m0_addr_i` in ADDR_W: port 0 line address
- `m0_data_i` in LINE_W: port 0 write data
- `m0_data_o` out LINE_W: read data, valid only while `m0_ack_o`
- `m0_ack_o` out 1: port 0 completion, one-cycle pulse
- `m1_*`: same six signals for port 1 (dcache)
- `mem_enable_o` out 1: to data memory
- `mem_write_o` out 1: to data memory
- `mem_addr_o` out ADDR_W: to data memory
- `mem_data_o` out LINE_W: to data memory
- `mem_data_i` in LINE_W: from data memory
- `mem_ack_i` in 1: from data memory; one-cycle pulse
- `busy_o` out 1: transaction in flight
- `grant_o` out 1: port of the current or last grant (0/1)
- `err_o` out 1: sticky watchdog error

## Operation
- States: IDLE, BUSY.
- IDLE:
  - If any `mX_enable_i` is high, choose the winner and latch its write/addr/data into internal registers.
  - Set `grant_o` to the winner and go to BUSY.
  - With no request, stay in IDLE.
- Winner selection (round-robin):
  - One requester: it wins.
  - Both requesters: the port that is not `grant_o` wins.
  - `grant_o` resets to 1, so port 0 wins the first contention.
- BUSY:
  - `mem_enable_o`=1; `mem_write_o`/`mem_addr_o`/`mem_data_o` come from the latched registers.
  - Requester inputs are ignored, including a dropped enable; the transaction completes regardless.
  - On `mem_ack_i`: pulse `mX_ack_o` for the granted port in that cycle only, then go to IDLE.
- `m0_data_o` and `m1_data_o` both equal `mem_data_i` combinationally. Only the ack qualifies the data.
- `mem_ack_i` while in IDLE is ignored; no ack is forwarded.
- Watchdog:
  - Counter clears on entry to BUSY and increments each BUSY cycle.
  - When the count reaches `TO_CYCLES` (and `TO_CYCLES`≠0), set `err_o`. It stays set until reset.
  - The transaction keeps waiting for `mem_ack_i`.
  - The counter saturates; it does not wrap.
- Reset, including mid-transaction: go to IDLE immediately.
  - `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
  - Both acks 0, `busy_o`=0, `grant_o`=1, `err_o`=0, counter 0.
  - The in-flight request is dropped; requesters re-request after reset.

## Timing
- Request sampled at edge E → `mem_enable_o` high from E (registered); one cycle of arbitration latency.
- `mem_ack_i` high in cycle K → `mX_ack_o` high in the same cycle K (combinational from `mem_ack_i` AND BUSY AND grant).
- Edge K+1 → IDLE, `mem_enable_o` low.
- Memory always sees at least one enable-low cycle between transactions. The earliest next grant is edge K+2.
- A requester that keeps enable high after its ack (e.g. write-back followed by refill) is re-arbitrated in IDLE; the other port wins if it is also requesting.
- `busy_o` is high exactly while in BUSY; it equals `mem_enable_o`.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum {IDLE, BUSY}
  - `LINE_W`/`ADDR_W` defaults
  - port-index constants `PORT_IC`=0, `PORT_DC`=1
- Sub-module `rr_pick2`: combinational 2-way round-robin selector.
  - Inputs: req[1:0], last.
  - Outputs: any, winner.
- The top level holds the FSM, request latches, ack routing and watchdog.

## Test plan
- Single read, port 0: `m0_enable_i`=1, addr 0x0000_0400, read; memory acks 10 cycles later with data 0xA5…A5.
  - `mem_addr_o`=0x400 and `mem_write_o`=0 while busy.
  - `m0_ack_o` pulses once with `m0_data_o`=0xA5…A5; `m1_ack_o` stays 0.
- Simultaneous requests after reset: port 0 granted first. After its ack, port 1 is granted at edge K+2.
  - Both ports held high continuously → grants alternate 0,1,0,1.
- Port 1 write-back then refill: write 0x800 with data D, then immediate read 0xC00.
  - Memory sees write 0x800/D, then one enable-low cycle, then read 0xC00.
  - Port 1 gets two separate ack pulses.
- Port 1 drops enable mid-BUSY: `mem_enable_o` stays 1 with the latched address until `mem_ack_i`, then IDLE. `m1_ack_o` still pulses.
- Watchdog with `TO_CYCLES`=8 and no ack: `err_o` rises after 8 busy cycles and stays high. A late ack completes normally. `rst_i` clears `err_o`.
- Reset asserted mid-BUSY: all outputs return to reset values asynchronously. A stray `mem_ack_i` afterwards produces no port ack.
